pc_sequencer: RTL and testbench

Multi-cycle fetch/execute sequencer for the 37-bit ISA processor. Owns the 10-bit program counter and steps the core through fetch, decode and execute. It handshakes with instruction memory and the execute datapath, and applies jump/branch redirects once per retired instruction. It sits between instruction memory, the instruction decoder and the ALU/datapath, and replaces the free-running PC increment with an enable-controlled update.

---
 rtl/pc_seq_if.sv | 36 +++
 rtl/pc_sequencer.sv | 119 +++++++++++
 tb/tb_pc_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_if.sv
// Handshake bundle between the fetch/execute sequencer and its environment
// (instruction memory, decoder and execute datapath).
interface pc_seq_if;
  logic        start;
  logic        imem_ready;
  logic [36:0] imem_rdata;
  logic        ex_done;
  logic        branch;
  logic        jump;
  logic        zero;
  logic        is_bne;
  logic        halt_instr;
  logic [15:0] immediate;
  logic [25:0] jump_address;

  logic [9:0]  pc;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [36:0] ir;
  logic        ex_start;
  logic [15:0] retire_count;
  logic [2:0]  state;
  logic        fault;

  modport master (
    input  start, imem_ready, imem_rdata, ex_done, branch, jump, zero, is_bne,
           halt_instr, immediate, jump_address,
    output pc, imem_req, imem_addr, ir, ex_start, retire_count, state, fault
  );

  modport slave (
    output start, imem_ready, imem_rdata, ex_done, branch, jump, zero, is_bne,
           halt_instr, immediate, jump_address,
    input  pc, imem_req, imem_addr, ir, ex_start, retire_count, state, fault
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer owning the 10-bit program counter.
// The PC advances only when an instruction retires (ex_done in EXECUTE).
module pc_sequencer #(
  parameter logic [9:0] PROGRAM_LOAD_ADDRESS = 10'h200,
  parameter int         FETCH_TIMEOUT        = 255
) (
  input  logic      clk,
  input  logic      reset,
  pc_seq_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    HALTED  = 3'd4,
    FAULT   = 3'd5
  } state_t;

  // Wait count value on the last permitted FETCH cycle before faulting.
  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [9:0]  pc_reg, pc_next;
  logic [36:0] ir_reg;
  logic [15:0] retire_reg;
  logic [7:0]  wait_reg;

  logic        fetch_accept;
  logic        fetch_expire;
  logic        retire;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        unused_bits;

  assign fetch_accept  = (state_reg == FETCH) && bus.imem_ready;
  assign fetch_expire  = (state_reg == FETCH) && !bus.imem_ready && (wait_reg == TIMEOUT_LAST);
  assign retire        = (state_reg == EXECUTE) && bus.ex_done;
  assign branch_taken  = bus.branch && ((bus.zero && !bus.is_bne) || (!bus.zero && bus.is_bne));
  assign branch_offset = {bus.immediate[15], bus.immediate[15], bus.immediate[13:0]};
  assign unused_bits   = ^{bus.jump_address[25:10], branch_offset[15:10]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = FETCH;
      FETCH: begin
        if (fetch_accept) begin
          state_next = DECODE;
        end else if (fetch_expire) begin
          state_next = FAULT;
        end
      end
      DECODE:  state_next = EXECUTE;
      EXECUTE: if (bus.ex_done) state_next = bus.halt_instr ? HALTED : FETCH;
      default: state_next = state_reg;
    endcase
  end

  // Jump beats a taken branch; all arithmetic wraps in the 10-bit space.
  always_comb begin
    pc_next = pc_reg + 10'd1;
    if (bus.jump) begin
      pc_next = bus.jump_address[9:0];
    end else if (branch_taken) begin
      pc_next = pc_reg + branch_offset[9:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg     <= PROGRAM_LOAD_ADDRESS;
      ir_reg     <= '0;
      retire_reg <= '0;
      wait_reg   <= '0;
    end else begin
      if (fetch_accept) begin
        ir_reg <= bus.imem_rdata;
      end
      if (retire) begin
        pc_reg     <= pc_next;
        retire_reg <= retire_reg + 16'd1;
      end
      // Zero whenever outside FETCH, so every FETCH entry starts from a clean count.
      if ((state_reg == FETCH) && !bus.imem_ready) begin
        wait_reg <= wait_reg + 8'd1;
      end else begin
        wait_reg <= '0;
      end
    end
  end

  always_comb begin
    bus.pc           = pc_reg;
    bus.imem_addr    = pc_reg;
    bus.ir           = ir_reg;
    bus.retire_count = retire_reg;
    bus.state        = state_reg;
    bus.imem_req     = 1'b0;
    bus.ex_start     = 1'b0;
    bus.fault        = 1'b0;
    case (state_reg)
      FETCH:   bus.imem_req = 1'b1;
      DECODE:  bus.ex_start = 1'b1;
      FAULT:   bus.fault    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a transaction-level model of expected
// architectural state, checked against the DUT on every falling edge.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_seq_if bus ();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXECUTE = 3, S_HALTED = 4, S_FAULT = 5;

  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  int          exp_state;
  logic [9:0]  exp_pc;
  logic [36:0] exp_ir;
  logic [15:0] exp_rc;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model; handshake outputs follow from the state.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("state", 64'(bus.state), 64'(exp_state));
      cmp("pc", 64'(bus.pc), 64'(exp_pc));
      cmp("imem_addr", 64'(bus.imem_addr), 64'(exp_pc));
      cmp("ir", 64'(bus.ir), 64'(exp_ir));
      cmp("retire_count", 64'(bus.retire_count), 64'(exp_rc));
      cmp("imem_req", 64'(bus.imem_req), 64'(exp_state == S_FETCH));
      cmp("ex_start", 64'(bus.ex_start), 64'(exp_state == S_DECODE));
      cmp("fault", 64'(bus.fault), 64'(exp_state == S_FAULT));
    end
  end

  function automatic logic [9:0] model_next_pc(input logic [9:0] p, input bit jp,
      input logic [25:0] ja, input bit br, input bit z, input bit bne, input logic [15:0] imm);
    int t;
    if (jp) return ja[9:0];
    if (br && (z != bne)) begin
      t = int'(p) + int'($signed(imm));
      return 10'(((t % 1024) + 1024) % 1024);
    end
    return 10'((int'(p) + 1) % 1024);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.imem_ready = 0; bus.imem_rdata = '0; bus.ex_done = 0;
    bus.branch = 0; bus.jump = 0; bus.zero = 0; bus.is_bne = 0; bus.halt_instr = 0;
    bus.immediate = '0; bus.jump_address = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_state = S_IDLE; exp_pc = 10'h200; exp_ir = '0; exp_rc = '0;
    chk_en = 1'b1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    exp_state = S_FETCH;
  endtask

  // One full instruction from FETCH; stray inputs are driven where they must be ignored.
  task automatic run_instr(input logic [36:0] word, input int fdelay, input int edelay,
      input bit br, input bit jp, input bit z, input bit bne, input bit hlt,
      input logic [15:0] imm, input logic [25:0] ja);
    logic [9:0] np;
    for (int i = 0; i < fdelay; i++) begin
      bus.imem_ready = 0; bus.imem_rdata = ~word;
      bus.ex_done = 1; bus.halt_instr = 1; bus.jump = 1;
      step();
    end
    bus.ex_done = 0; bus.halt_instr = 0; bus.jump = 0;
    bus.imem_ready = 1; bus.imem_rdata = word;
    step();
    exp_ir = word; exp_state = S_DECODE;
    bus.imem_rdata = ~word;
    step();
    exp_state = S_EXECUTE;
    for (int i = 0; i < edelay; i++) begin
      bus.ex_done = 0; bus.jump = 1; bus.jump_address = 26'h0; bus.halt_instr = 1; bus.start = 1;
      step();
    end
    bus.start = 0; bus.imem_ready = 0;
    bus.ex_done = 1; bus.branch = br; bus.jump = jp; bus.zero = z; bus.is_bne = bne;
    bus.halt_instr = hlt; bus.immediate = imm; bus.jump_address = ja;
    np = model_next_pc(exp_pc, jp, ja, br, z, bne, imm);
    step();
    exp_pc = np; exp_rc = exp_rc + 16'd1;
    exp_state = hlt ? S_HALTED : S_FETCH;
    clear_inputs();
  endtask

  task automatic seq_instr(input logic [36:0] word);
    run_instr(word, 0, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0);
  endtask

  task automatic jump_to(input logic [25:0] ja);
    run_instr(37'h0_0000_00AA, 0, 0, 0, 1, 0, 0, 0, 16'h0, ja);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    step();
    do_reset();
    cmp("lit_reset_pc", 64'(bus.pc), 64'h200);
    cmp("lit_reset_state", 64'(bus.state), 64'd0);

    // Handshake inputs in IDLE are ignored.
    bus.imem_ready = 1; bus.ex_done = 1; bus.jump = 1;
    step(); step();
    clear_inputs();

    do_start();
    seq_instr(37'h1_2345_6789);
    seq_instr(37'h0_0000_0001);
    seq_instr(37'h1_FFFF_FFFF);
    cmp("lit_seq_pc", 64'(bus.pc), 64'h203);
    cmp("lit_seq_rc", 64'(bus.retire_count), 64'd3);

    jump_to(26'h3_FC05);
    cmp("lit_jump_pc", 64'(bus.pc), 64'h005);
    run_instr(37'h5, 0, 0, 1, 1, 1, 0, 0, 16'h0004, 26'h0210);
    cmp("lit_jump_wins", 64'(bus.pc), 64'h210);
    run_instr(37'h6, 0, 0, 1, 0, 1, 0, 0, 16'hFFFE, 26'h0);
    cmp("lit_beq_taken", 64'(bus.pc), 64'h20E);
    jump_to(26'h0210);
    run_instr(37'h7, 0, 0, 1, 0, 0, 0, 0, 16'hFFFE, 26'h0);
    cmp("lit_beq_not", 64'(bus.pc), 64'h211);
    jump_to(26'h0210);
    run_instr(37'h8, 0, 0, 1, 0, 0, 1, 0, 16'h0004, 26'h0);
    cmp("lit_bne_taken", 64'(bus.pc), 64'h214);
    run_instr(37'h9, 0, 0, 1, 0, 1, 1, 0, 16'h0004, 26'h0);
    cmp("lit_bne_not", 64'(bus.pc), 64'h215);

    jump_to(26'h03FF);
    seq_instr(37'hA);
    cmp("lit_wrap_pc", 64'(bus.pc), 64'h000);
    run_instr(37'hB, 0, 0, 1, 0, 1, 0, 0, 16'hFFFE, 26'h0);
    cmp("lit_neg_wrap", 64'(bus.pc), 64'h3FE);

    run_instr(37'h0_DEAD_BEEF, 10, 3, 0, 0, 0, 0, 0, 16'h0, 26'h0);
    run_instr(37'h1_0BAD_F00D, 254, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0);
    cmp("lit_late_ready_rc", 64'(bus.retire_count), 64'd16);
    cmp("lit_late_ready_ir", 64'(bus.ir), 64'h1_0BAD_F00D);

    jump_to(26'h0205);
    run_instr(37'hC, 0, 0, 0, 0, 0, 0, 1, 16'h0, 26'h0);
    cmp("lit_halt_pc", 64'(bus.pc), 64'h206);
    cmp("lit_halt_state", 64'(bus.state), 64'd4);
    cmp("lit_halt_rc", 64'(bus.retire_count), 64'd18);
    bus.start = 1; bus.imem_ready = 1; bus.ex_done = 1; bus.jump = 1;
    repeat (4) step();
    clear_inputs();

    do_reset();
    cmp("lit_reset2_rc", 64'(bus.retire_count), 64'd0);

    // Reset during a fetch abandons it; a late ready in IDLE is ignored.
    do_start();
    repeat (3) step();
    reset = 1; bus.imem_ready = 1; bus.imem_rdata = 37'h1_5555_5555;
    step();
    reset = 0;
    exp_state = S_IDLE; exp_pc = 10'h200; exp_ir = '0; exp_rc = '0;
    step();
    clear_inputs();

    // Reset during EXECUTE wins over ex_done: no retire.
    do_start();
    bus.imem_ready = 1; bus.imem_rdata = 37'h0_1234_0000;
    step();
    exp_ir = 37'h0_1234_0000; exp_state = S_DECODE;
    bus.imem_ready = 0;
    step();
    exp_state = S_EXECUTE;
    step();
    reset = 1; bus.ex_done = 1; bus.jump = 1; bus.jump_address = 26'h0077;
    step();
    reset = 0;
    exp_state = S_IDLE; exp_pc = 10'h200; exp_ir = '0; exp_rc = '0;
    clear_inputs();
    cmp("lit_abort_rc", 64'(bus.retire_count), 64'd0);
    cmp("lit_abort_pc", 64'(bus.pc), 64'h200);

    // Fetch timeout: FAULT at the end of the 255th ready-less FETCH cycle.
    do_start();
    for (int i = 1; i <= 255; i++) begin
      bus.imem_ready = 0;
      step();
      if (i == 255) exp_state = S_FAULT;
    end
    cmp("lit_fault", 64'(bus.fault), 64'd1);
    cmp("lit_fault_state", 64'(bus.state), 64'd5);
    cmp("lit_fault_pc", 64'(bus.pc), 64'h200);
    bus.start = 1; bus.imem_ready = 1; bus.ex_done = 1;
    repeat (3) step();
    clear_inputs();
    do_reset();
    cmp("lit_fault_reset_state", 64'(bus.state), 64'd0);
    cmp("lit_fault_reset_fault", 64'(bus.fault), 64'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
